replay_mem_arbiter: RTL and testbench
=====================================

# replay_mem_arbiter

Arbiter and address controller for the replay-memory bank of the RL accelerator. It shares one single-port synchronous SRAM between two requesters: the experience writer, which stores transitions, and the sampler, which fetches entries by index. It owns the circular write pointer and the saturating fill count, which tracks how many entries are valid. It returns read data with a fixed one-cycle latency and flags out-of-range reads.

## Interface
Parameters:
- DEPTH, 16: number of memory entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH): address/index width.
- DW, 32: entry data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of the buffer (empties it).
- wr_req  in  1  writer requests to store wr_data; held high until granted.
- wr_data  in  DW  entry to store.
- wr_gnt  out  1  write granted this cycle (combinational).
- rd_req  in  1  sampler requests entry rd_idx; held high until granted.
- rd_idx  in  AW  physical entry index to read.
- rd_gnt  out  1  read granted this cycle (combinational).
- rd_valid  out  1  read response valid, one cycle after rd_gnt.
- rd_data  out  DW  read response data.
- rd_err  out  1  response is for an index that is not valid (rd_idx >= entry_cnt at grant time).
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data; valid the cycle after an enabled read.
- entry_cnt  out  AW+1  number of valid entries, 0..DEPTH.
- full  out  1  asserted when entry_cnt == DEPTH.

## Operation
- State:
  - wr_ptr: AW bits, circular.
  - entry_cnt: AW+1 bits, saturating.
  - prio: 1 bit, 0 = writer favoured, 1 = sampler favoured.
  - rd_pend, rd_pend_err: 1 bit each.
- Arbitration (suppressed while rst or clear is high): at most one grant per cycle.
  - Only wr_req high: wr_gnt = 1.
  - Only rd_req high: rd_gnt = 1.
  - Both high: grant goes to the side selected by prio.
- prio update:
  - After any wr_gnt, prio becomes 1.
  - After any rd_gnt, prio becomes 0.
  - With no grant, prio holds.
  - Result: strict alternation under contention.
- Write grant:
  - mem_en = 1, mem_we = 1, mem_addr = wr_ptr, mem_wdata = wr_data.
  - Next edge: wr_ptr becomes (wr_ptr + 1) mod DEPTH, wrapping from DEPTH-1 to 0.
  - Next edge: entry_cnt becomes min(entry_cnt + 1, DEPTH).
  - A write when full still proceeds and overwrites the oldest entry; entry_cnt stays at DEPTH.
- Read grant, in range (rd_idx < entry_cnt):
  - mem_en = 1, mem_we = 0, mem_addr = rd_idx.
  - Next edge: rd_pend = 1, rd_pend_err = 0.
- Read grant, out of range:
  - mem_en = 0.
  - Next edge: rd_pend = 1, rd_pend_err = 1.
- Read response:
  - rd_valid = rd_pend.
  - rd_err = rd_pend_err.
  - rd_data = mem_rdata when rd_pend and not rd_pend_err; otherwise 0.
- No grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- clear:
  - No grants in that cycle.
  - Next edge: wr_ptr = 0, entry_cnt = 0, prio = 0.
  - A response already pending from the previous cycle's grant is still delivered unchanged.
- rst:
  - Same effect as clear.
  - Additionally, next edge: rd_pend = 0, rd_pend_err = 0, so a pending response is dropped.

## Timing
- Values after a rst edge:
  - wr_gnt = 0, rd_gnt = 0, rd_valid = 0, rd_err = 0, rd_data = 0.
  - mem_en = 0, mem_we = 0.
  - entry_cnt = 0, full = 0.
  - wr_ptr = 0, prio = 0.
- Grants and SRAM controls are combinational from requests and registered state, in the same cycle as the request.
- Request-to-response latency: a read granted in cycle N gives rd_valid in cycle N+1.
- Back-to-back reads with no contention give one response per cycle.
- Effect of a write granted in cycle N: entry_cnt and full reflect it from cycle N+1.
- The range check for a read in cycle N uses the cycle-N entry_cnt.
- Same-cycle write and read never occur, because the SRAM is single-port.
- full is combinational from the entry_cnt register.

## Test plan
- Reset with wr_req high -> wr_gnt = 0 during rst. After release, the first cycle grants the write at mem_addr 0, and entry_cnt = 1 the next cycle.
- DEPTH = 4, five writes of 0xA0..0xA4 -> addresses 0,1,2,3,0. full rises after the 4th write. entry_cnt stays at 4. Reading index 0 then returns 0xA4 with rd_err = 0.
- wr_req and rd_req held high together for 6 cycles -> grants go W, R, W, R, W, R (prio starts at 0). Each rd_gnt is followed one cycle later by rd_valid.
- entry_cnt = 2, read of index 3 -> rd_gnt = 1 and mem_en = 0. Next cycle rd_valid = 1, rd_err = 1, rd_data = 0.
- clear asserted in the cycle after a read grant of index 1 (entry 1 = 0x55) -> rd_valid = 1 with rd_data = 0x55 in the clear cycle. No grants in the clear cycle. Next cycle entry_cnt = 0, full = 0, and the next write goes to address 0.
- rst asserted in the cycle after a read grant -> rd_valid = 0 in the following cycle, and every output returns to its reset value.

Source files
------------

// File: rtl/replay_mem_arbiter_if.sv
// Bundle for the replay-memory arbiter: writer and sampler handshakes, SRAM port and fill status.
// master = requesters plus SRAM model side, slave = arbiter side.
interface replay_mem_arbiter_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
);
  logic          clear;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_idx;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW:0]   entry_cnt;
  logic          full;

  modport master (
    output clear, wr_req, wr_data, rd_req, rd_idx, mem_rdata,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, rd_err,
           mem_en, mem_we, mem_addr, mem_wdata, entry_cnt, full
  );

  modport slave (
    input  clear, wr_req, wr_data, rd_req, rd_idx, mem_rdata,
    output wr_gnt, rd_gnt, rd_valid, rd_data, rd_err,
           mem_en, mem_we, mem_addr, mem_wdata, entry_cnt, full
  );
endinterface

// File: rtl/replay_mem_arbiter.sv
// Shares one single-port SRAM between the experience writer and the sampler; owns the
// circular write pointer and saturating fill count, returns read data one cycle after grant.
module replay_mem_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input logic                 clk,
  input logic                 rst,
  replay_mem_arbiter_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          prio;
  logic          rd_pend;
  logic          rd_pend_err;
  logic          blocked;
  logic          in_range;

  always_comb begin
    blocked        = rst | bus.clear;
    in_range       = ({1'b0, bus.rd_idx} < cnt);
    // prio only matters under contention: 0 favours the writer, 1 the sampler
    bus.wr_gnt     = !blocked && bus.wr_req && (!bus.rd_req || !prio);
    bus.rd_gnt     = !blocked && bus.rd_req && (!bus.wr_req || prio);
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (bus.wr_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = wr_ptr;
      bus.mem_wdata = bus.wr_data;
    end else if (bus.rd_gnt && in_range) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.rd_idx;
    end
    bus.rd_valid  = rd_pend;
    bus.rd_err    = rd_pend_err;
    bus.rd_data   = (rd_pend && !rd_pend_err) ? bus.mem_rdata : '0;
    bus.entry_cnt = cnt;
    bus.full      = (cnt == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (blocked) begin
      wr_ptr <= '0;
      cnt    <= '0;
      prio   <= 1'b0;
    end else begin
      if (bus.wr_gnt) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (cnt != FULL_CNT) cnt <= cnt + 1'b1;
        prio <= 1'b1;
      end
      if (bus.rd_gnt) prio <= 1'b0;
    end
    // clear alone lets the previous cycle's response through; rst drops it
    if (rst) begin
      rd_pend     <= 1'b0;
      rd_pend_err <= 1'b0;
    end else begin
      rd_pend     <= bus.rd_gnt;
      rd_pend_err <= bus.rd_gnt && !in_range;
    end
  end
endmodule

// File: tb/tb_replay_mem_arbiter.sv
// Directed table-driven bench for replay_mem_arbiter with DEPTH = 4 and a behavioural SRAM.
module tb_replay_mem_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 32;

  typedef struct {
    logic          rst, clr, wr;
    logic [DW-1:0] wd;
    logic          rd;
    logic [AW-1:0] ri;
    logic          wg, rg, en, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rv, re;
    logic [DW-1:0] rdata;
    logic [AW:0]   cnt;
    logic          full;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [DW-1:0] ram [DEPTH];

  replay_mem_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  replay_mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(
    input logic rst_i, clr, wr, input logic [DW-1:0] wd, input logic rd, input logic [AW-1:0] ri,
    input logic wg, rg, en, we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
    input logic rv, re, input logic [DW-1:0] rdata, input logic [AW:0] cnt, input logic full);
    vec_t r;
    r.rst = rst_i; r.clr = clr; r.wr = wr; r.wd = wd; r.rd = rd; r.ri = ri;
    r.wg = wg; r.rg = rg; r.en = en; r.we = we; r.addr = addr; r.wdata = wdata;
    r.rv = rv; r.re = re; r.rdata = rdata; r.cnt = cnt; r.full = full;
    return r;
  endfunction

  task automatic drive(input logic r, c, w, input logic [DW-1:0] wd, input logic rq, input logic [AW-1:0] ri);
    rst         = r;
    bus.clear   = c;
    bus.wr_req  = w;
    bus.wr_data = wd;
    bus.rd_req  = rq;
    bus.rd_idx  = ri;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    checks   = 0;
    failures = 0;
    //                rst clr wr wd         rd ri   wg rg en we addr wdata      rv re rdata      cnt full
    tbl.push_back(v(1, 0, 1, 32'hA0, 0, 0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0));
    tbl.push_back(v(0, 0, 1, 32'hA0, 0, 0,  1, 0, 1, 1, 0, 32'hA0, 0, 0, 32'h0,  0, 0));
    tbl.push_back(v(0, 0, 1, 32'hA1, 0, 0,  1, 0, 1, 1, 1, 32'hA1, 0, 0, 32'h0,  1, 0));
    tbl.push_back(v(0, 0, 1, 32'hA2, 0, 0,  1, 0, 1, 1, 2, 32'hA2, 0, 0, 32'h0,  2, 0));
    tbl.push_back(v(0, 0, 1, 32'hA3, 0, 0,  1, 0, 1, 1, 3, 32'hA3, 0, 0, 32'h0,  3, 0));
    tbl.push_back(v(0, 0, 1, 32'hA4, 0, 0,  1, 0, 1, 1, 0, 32'hA4, 0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,  0, 1, 1, 0, 0, 32'h0,  0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 32'h0,  1, 0, 32'hA4, 4, 1));
    // contention: W R W R W R
    tbl.push_back(v(0, 0, 1, 32'hB0, 1, 1,  1, 0, 1, 1, 1, 32'hB0, 0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 1, 32'hB1, 1, 1,  0, 1, 1, 0, 1, 32'h0,  0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 1, 32'hB1, 1, 1,  1, 0, 1, 1, 2, 32'hB1, 1, 0, 32'hB0, 4, 1));
    tbl.push_back(v(0, 0, 1, 32'hB2, 1, 2,  0, 1, 1, 0, 2, 32'h0,  0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 1, 32'hB2, 1, 2,  1, 0, 1, 1, 3, 32'hB2, 1, 0, 32'hB1, 4, 1));
    tbl.push_back(v(0, 0, 1, 32'hB3, 1, 3,  0, 1, 1, 0, 3, 32'h0,  0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 32'h0,  1, 0, 32'hB2, 4, 1));
    // clear, refill to 2, out-of-range read of index 3
    tbl.push_back(v(0, 1, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,  4, 1));
    tbl.push_back(v(0, 0, 1, 32'h50, 0, 0,  1, 0, 1, 1, 0, 32'h50, 0, 0, 32'h0,  0, 0));
    tbl.push_back(v(0, 0, 1, 32'h55, 0, 0,  1, 0, 1, 1, 1, 32'h55, 0, 0, 32'h0,  1, 0));
    tbl.push_back(v(0, 0, 0, 32'h0,  1, 3,  0, 1, 0, 0, 0, 32'h0,  0, 0, 32'h0,  2, 0));
    tbl.push_back(v(0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 32'h0,  1, 1, 32'h0,  2, 0));
    // read index 1, then clear while its response is pending
    tbl.push_back(v(0, 0, 0, 32'h0,  1, 1,  0, 1, 1, 0, 1, 32'h0,  0, 0, 32'h0,  2, 0));
    tbl.push_back(v(0, 1, 1, 32'h66, 1, 0,  0, 0, 0, 0, 0, 32'h0,  1, 0, 32'h55, 2, 0));
    tbl.push_back(v(0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0));
    tbl.push_back(v(0, 0, 1, 32'h77, 0, 0,  1, 0, 1, 1, 0, 32'h77, 0, 0, 32'h0,  0, 0));
    // rd_idx == entry_cnt is out of range
    tbl.push_back(v(0, 0, 0, 32'h0,  1, 1,  0, 1, 0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0));
    tbl.push_back(v(0, 0, 0, 32'h0,  1, 0,  0, 1, 1, 0, 0, 32'h0,  1, 1, 32'h0,  1, 0));
    // rst while a response is pending drops it
    tbl.push_back(v(1, 0, 0, 32'h0,  1, 0,  0, 0, 0, 0, 0, 32'h0,  1, 0, 32'h77, 1, 0));
    tbl.push_back(v(0, 0, 0, 32'h0,  0, 0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0));

    drive(1, 0, 0, '0, 0, '0);
    next_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].ri);
      #4;
      chk($sformatf("v%0d.wr_gnt", i),    DW'(bus.wr_gnt),    DW'(tbl[i].wg));
      chk($sformatf("v%0d.rd_gnt", i),    DW'(bus.rd_gnt),    DW'(tbl[i].rg));
      chk($sformatf("v%0d.mem_en", i),    DW'(bus.mem_en),    DW'(tbl[i].en));
      chk($sformatf("v%0d.mem_we", i),    DW'(bus.mem_we),    DW'(tbl[i].we));
      chk($sformatf("v%0d.mem_addr", i),  DW'(bus.mem_addr),  DW'(tbl[i].addr));
      chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,      tbl[i].wdata);
      chk($sformatf("v%0d.rd_valid", i),  DW'(bus.rd_valid),  DW'(tbl[i].rv));
      chk($sformatf("v%0d.rd_err", i),    DW'(bus.rd_err),    DW'(tbl[i].re));
      chk($sformatf("v%0d.rd_data", i),   bus.rd_data,        tbl[i].rdata);
      chk($sformatf("v%0d.entry_cnt", i), DW'(bus.entry_cnt), DW'(tbl[i].cnt));
      chk($sformatf("v%0d.full", i),      DW'(bus.full),      DW'(tbl[i].full));
      next_cycle();
    end

    // fill from empty, then stream four reads back to back
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 32'hD0 + DW'(i), 0, '0);
      #4;
      chk($sformatf("fill%0d.wr_gnt", i),    DW'(bus.wr_gnt),    32'd1);
      chk($sformatf("fill%0d.mem_addr", i),  DW'(bus.mem_addr),  DW'(i));
      chk($sformatf("fill%0d.entry_cnt", i), DW'(bus.entry_cnt), DW'(i));
      next_cycle();
    end
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 0, 0, '0, (i < DEPTH), AW'(i));
      #4;
      if (i < DEPTH) chk($sformatf("b2b%0d.rd_gnt", i), DW'(bus.rd_gnt), 32'd1);
      chk($sformatf("b2b%0d.rd_valid", i), DW'(bus.rd_valid), DW'(i > 0));
      if (i > 0) chk($sformatf("b2b%0d.rd_data", i), bus.rd_data, 32'hD0 + DW'(i - 1));
      next_cycle();
    end
    #4;
    chk("final.entry_cnt", DW'(bus.entry_cnt), 32'd4);
    chk("final.full",      DW'(bus.full),      32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
